// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types for the pipeline hazard controller.
//   HazardState : divide wait FSM state (run / waiting on the divider)
//   StallCause  : which hazard event owns the pipeline controls this cycle
//   div_cnt_width() : counter width needed to hold DIV_CYCLES-1
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {HZ_RUN, HZ_DIV} HazardState;

    typedef enum logic [2:0] {NONE, EXC, DCB, DIV, ICB, LU, BR} StallCause;

    function automatic int unsigned div_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_wait_fsm.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_div_wait_fsm
// Tracks a multi-cycle divide sitting in EXE. Launches the divider once per
// divide, counts the wait down, and cancels the divide when an exception hits.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   EXE_IsDiv       EXE holds a DIV/DIVU
//   DCache_Busy     MEM stall; freezes the wait counter and blocks start/finish
//   abort           exception redirect is taking the pipeline this cycle
//   div_stall       divide still needs EXE held (raw, before priority)
//   Div_Start       one-cycle launch pulse
//   Div_Abort       one-cycle cancel pulse
// -----------------------------------------------------------------------------
module hazard_ctrl_div_wait_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic EXE_IsDiv,
    input  logic DCache_Busy,
    input  logic abort,
    output logic div_stall,
    output logic Div_Start,
    output logic Div_Abort
);

    localparam int unsigned CntW = div_cnt_width(DIV_CYCLES);
    localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 1);

    HazardState      r_state;
    HazardState      w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            w_in_div;

    assign w_in_div  = (r_state == HZ_DIV);
    assign div_stall = (!w_in_div && EXE_IsDiv) || (w_in_div && (r_cnt != '0));

    // A start only happens when the divide event actually owns the pipeline,
    // i.e. neither the exception redirect nor a D-cache stall outranks it.
    assign Div_Start = rst && !w_in_div && EXE_IsDiv && !abort && !DCache_Busy;
    assign Div_Abort = rst && w_in_div && abort;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (Div_Abort) begin
            w_state_nxt = HZ_RUN;
            w_cnt_nxt   = '0;
        end else if (Div_Start) begin
            w_state_nxt = HZ_DIV;
            w_cnt_nxt   = CntLoad;
        end else if (w_in_div && !DCache_Busy) begin
            // Release only when MEM is free, otherwise the final EXE capture
            // would be swallowed by the D-cache stall.
            if (r_cnt == '0) begin
                w_state_nxt = HZ_RUN;
            end else begin
                w_cnt_nxt = r_cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control for the five-stage pipeline: picks the highest-priority
// hazard each cycle and drives stage write enables and flushes.
// Priority: exception redirect, D-cache busy, divide wait, load-use,
// I-cache busy, taken branch. Load-use outranks an I-cache miss because an
// I-cache bubble lets ID advance, which would carry the dependent
// instruction past its load.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   ICache_Busy, DCache_Busy          cache not ready this cycle
//   MEM_ExceptValid                   MEM-stage exception commit
//   EXE_BranchTaken                   taken branch/jump in EXE
//   EXE_IsLoad, EXE_IsDiv, EXE_rt     EXE instruction info
//   ID_rs, ID_rt, ID_UsesRs, ID_UsesRt ID source operands
//   PC_Wr..WB_Wr                      stage register capture enables
//   ID_Flush..WB_Flush                stage register bubble controls
//   Div_Start, Div_Abort              divider launch / cancel pulses
//   Perf_StallCycles, Perf_LoadUseCnt only with HAZARD_PERF_CNT_EN defined
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ICache_Busy,
    input  logic       DCache_Busy,
    input  logic       MEM_ExceptValid,
    input  logic       EXE_BranchTaken,
    input  logic       EXE_IsLoad,
    input  logic       EXE_IsDiv,
    input  logic [4:0] EXE_rt,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    output logic       PC_Wr,
    output logic       ID_Wr,
    output logic       EXE_Wr,
    output logic       MEM_Wr,
    output logic       WB_Wr,
    output logic       ID_Flush,
    output logic       EXE_Flush,
    output logic       MEM_Flush,
    output logic       WB_Flush,
    output logic       Div_Start,
    output logic       Div_Abort
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Perf_StallCycles,
    output logic [31:0] Perf_LoadUseCnt
`endif
);

    logic      w_exc;
    logic      w_lu;
    logic      w_div_stall;
    StallCause w_cause;

    assign w_exc = MEM_ExceptValid && !DCache_Busy;
    assign w_lu  = EXE_IsLoad && (EXE_rt != 5'd0) &&
                   ((ID_UsesRs && (ID_rs == EXE_rt)) || (ID_UsesRt && (ID_rt == EXE_rt)));

    hazard_ctrl_div_wait_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .EXE_IsDiv   (EXE_IsDiv),
        .DCache_Busy (DCache_Busy),
        .abort       (w_exc),
        .div_stall   (w_div_stall),
        .Div_Start   (Div_Start),
        .Div_Abort   (Div_Abort)
    );

    always_comb begin
        w_cause = NONE;
        if (w_exc) begin
            w_cause = EXC;
        end else if (DCache_Busy) begin
            w_cause = DCB;
        end else if (w_div_stall) begin
            w_cause = DIV;
        end else if (w_lu) begin
            w_cause = LU;
        end else if (ICache_Busy) begin
            w_cause = ICB;
        end else if (EXE_BranchTaken) begin
            w_cause = BR;
        end
    end

    // A register that is flushed never also has its write enable raised.
    always_comb begin
        PC_Wr     = 1'b1;
        ID_Wr     = 1'b1;
        EXE_Wr    = 1'b1;
        MEM_Wr    = 1'b1;
        WB_Wr     = 1'b1;
        ID_Flush  = 1'b0;
        EXE_Flush = 1'b0;
        MEM_Flush = 1'b0;
        WB_Flush  = 1'b0;
        case (w_cause)
            EXC: begin
                {ID_Wr, EXE_Wr, MEM_Wr, WB_Wr}             = 4'b0000;
                {ID_Flush, EXE_Flush, MEM_Flush, WB_Flush} = 4'b1111;
            end
            DCB: begin
                {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr} = 5'b00000;
                WB_Flush                              = 1'b1;
            end
            DIV: begin
                {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr} = 4'b0000;
                MEM_Flush                      = 1'b1;
            end
            LU: begin
                {PC_Wr, ID_Wr, EXE_Wr} = 3'b000;
                EXE_Flush              = 1'b1;
            end
            ICB: begin
                {PC_Wr, ID_Wr} = 2'b00;
                ID_Flush       = 1'b1;
            end
            BR: begin
                ID_Wr    = 1'b0;
                ID_Flush = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr}      = 5'b00000;
            {ID_Flush, EXE_Flush, MEM_Flush, WB_Flush} = 4'b1111;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_lu;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_lu    <= '0;
        end else begin
            if (!PC_Wr) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_cause == LU) begin
                r_perf_lu <= r_perf_lu + 32'd1;
            end
        end
    end

    assign Perf_StallCycles = r_perf_stall;
    assign Perf_LoadUseCnt  = r_perf_lu;
`endif

endmodule
